grn_sim_ctrl: RTL and testbench

- Sequencer for a bank of NODES boolean network nodes.
- Each node has a half-rate state register s0 (tortoise, advances every second start) and a full-rate register s1 (hare).
- For each initial state in a programmed range, the block loads the nodes, steps them, and detects attractor entry with Floyd's algorithm (s0 vector == s1 vector).
- It streams one result per initial state through a valid/ready handshake. It sits between the host/config registers and the node array.

---
 rtl/grn_sim_ctrl_pkg.sv | 19 +
 rtl/grn_sim_ctrl_if.sv | 26 ++
 rtl/grn_sim_ctrl.sv | 179 +++++++++++++++++
 tb/tb_grn_sim_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/grn_sim_ctrl_pkg.sv
// Shared types and default widths for the boolean-network simulation sequencer.
package grn_ctrl_pkg;

  localparam int unsigned NODES_DEF  = 8;
  localparam int unsigned STEP_W_DEF = 16;
  localparam int unsigned PER_W_DEF  = 16;

  // Smallest usable hare-step limit; the first Floyd compare happens at step 2
  localparam int unsigned MIN_STEPS  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_RESULT = 3'd3,
    ST_PERIOD = 3'd4
  } state_t;

endpackage

// File: rtl/grn_sim_ctrl_if.sv
// Result stream of the sequencer: one record per initial state, valid/ready handshake.
interface grn_sim_ctrl_if #(
  parameter int unsigned NODES  = grn_ctrl_pkg::NODES_DEF,
  parameter int unsigned STEP_W = grn_ctrl_pkg::STEP_W_DEF,
  parameter int unsigned PER_W  = grn_ctrl_pkg::PER_W_DEF
) ();

  logic              res_valid;
  logic              res_ready;
  logic [NODES-1:0]  res_init;
  logic [NODES-1:0]  res_state;
  logic [STEP_W-1:0] res_steps;
  logic              res_timeout;
  logic [PER_W-1:0]  res_period;

  modport master (
    output res_valid, res_init, res_state, res_steps, res_timeout, res_period,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_init, res_state, res_steps, res_timeout, res_period,
    output res_ready
  );

endinterface

// File: rtl/grn_sim_ctrl.sv
// Sweeps initial states over a boolean-node bank and detects attractor entry (Floyd).
// Optional attractor period measurement enabled by GRN_PERIOD_MEASURE_EN.
module grn_sim_ctrl
  import grn_ctrl_pkg::*;
#(
  parameter int unsigned NODES  = NODES_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned PER_W  = PER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NODES-1:0]  init_first,
  input  logic [NODES-1:0]  init_last,
  input  logic [STEP_W-1:0] max_steps,
  output logic [NODES-1:0]  init_state,
  output logic              reset_nos,
  output logic              start_s0,
  output logic              start_s1,
  input  logic [NODES-1:0]  erm_s0,
  input  logic [NODES-1:0]  erm_s1,
  output logic              busy,
  output logic              done,
  grn_sim_ctrl_if.master    res
);

  state_t            state_q, state_d;
  logic [NODES-1:0]  cur_q, cur_d;
  logic [NODES-1:0]  last_q, last_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] limit;
  logic              busy_d, done_d;
  logic              cap_en, cap_to;
  logic              s_eq, match;

  assign limit      = (max_steps < STEP_W'(MIN_STEPS)) ? STEP_W'(MIN_STEPS) : max_steps;
  assign s_eq       = (erm_s0 == erm_s1);
  // Tortoise only lands on a fresh state after an even number of hare steps
  assign match      = s_eq && (step_q != '0) && !step_q[0];
  assign init_state = cur_q;

`ifdef GRN_PERIOD_MEASURE_EN
  logic [PER_W-1:0] per_q, per_d, per_val;
  logic             per_cap;
`endif

  // Next-state, counters and the same-cycle step strobes
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    step_d   = step_q;
    busy_d   = busy;
    done_d   = 1'b0;
    cap_en   = 1'b0;
    cap_to   = 1'b0;
    start_s0 = 1'b0;
    start_s1 = 1'b0;
`ifdef GRN_PERIOD_MEASURE_EN
    per_d    = per_q;
    per_val  = per_q;
    per_cap  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = init_first;
          last_d  = init_last;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        step_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (match) begin
          cap_en  = 1'b1;
`ifdef GRN_PERIOD_MEASURE_EN
          per_d   = '0;
          state_d = ST_PERIOD;
`else
          state_d = ST_RESULT;
`endif
        end else if (step_q == limit) begin
          cap_en  = 1'b1;
          cap_to  = 1'b1;
          state_d = ST_RESULT;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
          step_d   = step_q + STEP_W'(1);
        end
      end
`ifdef GRN_PERIOD_MEASURE_EN
      ST_PERIOD: begin
        if (s_eq && (per_q != '0)) begin
          per_cap = 1'b1;
          state_d = ST_RESULT;
        end else if (per_q == '1) begin
          per_cap = 1'b1;
          per_val = '1;
          state_d = ST_RESULT;
        end else begin
          start_s1 = 1'b1;
          per_d    = per_q + PER_W'(1);
        end
      end
`endif
      ST_RESULT: begin
        if (res.res_valid && res.res_ready) begin
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cur_d   = cur_q + NODES'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cur_q           <= '0;
      last_q          <= '0;
      step_q          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      reset_nos       <= 1'b0;
      res.res_valid   <= 1'b0;
      res.res_init    <= '0;
      res.res_state   <= '0;
      res.res_steps   <= '0;
      res.res_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      step_q        <= step_d;
      busy          <= busy_d;
      done          <= done_d;
      reset_nos     <= (state_d == ST_LOAD);
      res.res_valid <= (state_d == ST_RESULT);
      if (cap_en) begin
        res.res_init    <= cur_q;
        res.res_state   <= erm_s0;
        res.res_steps   <= step_q;
        res.res_timeout <= cap_to;
      end
    end
  end

`ifdef GRN_PERIOD_MEASURE_EN
  // Period counter and result; a timed-out record reports period 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q          <= '0;
      res.res_period <= '0;
    end else begin
      per_q <= per_d;
      if (cap_en) begin
        res.res_period <= '0;
      end
      if (per_cap) begin
        res.res_period <= per_val;
      end
    end
  end
`else
  assign res.res_period = PER_W'(0);
`endif

endmodule

// File: tb/tb_grn_sim_ctrl.sv
// Directed bench for grn_sim_ctrl with a behavioural 4-node bank (identity, toggle, ring counter).
module tb_grn_sim_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned PW = 4;
`ifdef GRN_PERIOD_MEASURE_EN
  localparam bit PM = 1'b1;
`else
  localparam bit PM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  init_first = '0;
  logic [N-1:0]  init_last = '0;
  logic [SW-1:0] max_steps = '0;
  logic [N-1:0]  init_state;
  logic          reset_nos, start_s0, start_s1, busy, done;
  logic [N-1:0]  s0, s1;
  logic          pass;
  int            net = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            bad_strobe = 0;

  grn_sim_ctrl_if #(.NODES(N), .STEP_W(SW), .PER_W(PW)) rif ();

  grn_sim_ctrl #(.NODES(N), .STEP_W(SW), .PER_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .init_first(init_first), .init_last(init_last), .max_steps(max_steps),
    .init_state(init_state), .reset_nos(reset_nos),
    .start_s0(start_s0), .start_s1(start_s1),
    .erm_s0(s0), .erm_s1(s1),
    .busy(busy), .done(done), .res(rif)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] f(input int kind, input logic [N-1:0] s);
    case (kind)
      0:       return s;
      1:       return ~s;
      default: return s + N'(1);
    endcase
  endfunction

  // Node bank: hare steps every strobe, tortoise on every second strobe
  always @(posedge clk) begin
    if (reset_nos) begin
      s0   <= init_state;
      s1   <= init_state;
      pass <= 1'b1;
    end else begin
      if (start_s1) s1 <= f(net, s1);
      if (start_s0) begin
        pass <= ~pass;
        if (!pass) s0 <= f(net, s0);
      end
    end
  end

  always @(posedge clk)
    if (rif.res_valid && (start_s0 || start_s1 || reset_nos)) bad_strobe <= bad_strobe + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [N-1:0] fi, input logic [N-1:0] la, input logic [SW-1:0] ms);
    init_first = fi;
    init_last  = la;
    max_steps  = ms;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rif.res_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(rif.res_valid), 32'd1);
  endtask

  task automatic take(input string tag, input logic [N-1:0] ei, input logic [N-1:0] es,
                      input logic [SW-1:0] est, input logic eto, input logic [PW-1:0] ep);
    wait_valid(tag);
    chk({tag, ".init"},    32'(rif.res_init),    32'(ei));
    chk({tag, ".state"},   32'(rif.res_state),   32'(es));
    chk({tag, ".steps"},   32'(rif.res_steps),   32'(est));
    chk({tag, ".timeout"}, 32'(rif.res_timeout), 32'(eto));
    chk({tag, ".period"},  32'(rif.res_period),  32'(PM ? ep : PW'(0)));
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
  endtask

  task automatic end_sweep(input string tag);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rif.res_ready = 1'b0;
    tick();
    tick();
    chk("rst.init_state", 32'(init_state), 32'd0);
    chk("rst.strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
    chk("rst.busy_done", 32'({busy, done}), 32'd0);
    chk("rst.res", 32'({rif.res_valid, rif.res_timeout, rif.res_steps}), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Identity network: every state is a fixed point, met at step 2
    net = 0;
    go(4'h0, 4'h3, 16'd16);
    chk("id.load", 32'({reset_nos, busy, init_state}), 32'({1'b1, 1'b1, 4'h0}));
    for (int i = 0; i < 4; i++) take($sformatf("id%0d", i), N'(i), N'(i), 16'd2, 1'b0, 4'd1);
    end_sweep("id");

    // Toggle network: two-cycle attractor
    net = 1;
    go(4'h1, 4'h1, 16'd16);
    take("tog", 4'h1, 4'h1, 16'd4, 1'b0, 4'd2);
    end_sweep("tog");

    // Ring counter, limit 3: times out, then ready held low for 10 cycles
    net = 2;
    go(4'h0, 4'h0, 16'd3);
    wait_valid("ring3");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d", i), 32'({rif.res_valid, rif.res_steps}), 32'({1'b1, 16'd3}));
      tick();
    end
    take("ring3", 4'h0, 4'h1, 16'd3, 1'b1, 4'd0);
    chk("ring3.adv", 32'(rif.res_valid), 32'd0);
    end_sweep("ring3");

    // max_steps of 0 behaves as 2
    go(4'h0, 4'h0, 16'd0);
    take("ring0", 4'h0, 4'h1, 16'd2, 1'b0 | 1'b1, 4'd0);
    end_sweep("ring0");

    // Ring meet after 32 steps; period 16 saturates a 4-bit counter at 15
    go(4'h5, 4'h5, 16'd40);
    take("ring40", 4'h5, 4'h5, 16'd32, 1'b0, 4'hF);
    end_sweep("ring40");

    // Wrapping sweep F,0,1 with an ignored start while busy
    net = 0;
    go(4'hF, 4'h1, 16'd16);
    take("wrapF", 4'hF, 4'hF, 16'd2, 1'b0, 4'd1);
    go(4'h7, 4'h7, 16'd16);
    take("wrap0", 4'h0, 4'h0, 16'd2, 1'b0, 4'd1);
    take("wrap1", 4'h1, 4'h1, 16'd2, 1'b0, 4'd1);
    end_sweep("wrap");

    // Asynchronous reset in the middle of RUN, then a full replay
    net = 2;
    go(4'h3, 4'h3, 16'd40);
    for (int i = 0; i < 6; i++) tick();
    chk("mid.run_strobe", 32'(start_s1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst_outs", 32'({init_state, reset_nos, start_s0, start_s1, busy, done}), 32'd0);
    chk("mid.rst_res", 32'({rif.res_valid, rif.res_steps}), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    go(4'h3, 4'h3, 16'd40);
    chk("replay.load", 32'({reset_nos, init_state}), 32'({1'b1, 4'h3}));
    take("replay", 4'h3, 4'h3, 16'd32, 1'b0, 4'hF);
    end_sweep("replay");

    chk("no_strobe_in_result", 32'(bad_strobe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
